// File: rtl/display_scan.sv
// display_scan: time-multiplexed digit scan for a 4-bit-to-7-segment converter.
// Double-buffered code bank; shadow writes commit to the displayed bank at frame end.
// Ports:
//   clk         system clock
//   rst         synchronous reset, active low
//   wr_en       shadow write strobe
//   wr_addr     digit index to write (out-of-range indices are ignored)
//   wr_data     4-bit code to store
//   blank_mask  bit i = 1 keeps digit i dark for its whole slot
//   number      code of the digit in the current slot
//   digit_sel   active-low digit enables, at most one low
//   frame_tick  one-cycle pulse on the last cycle of each frame
module display_scan #(
  parameter int NDIG     = 4,
  parameter int SCAN_DIV = 50000,
  parameter int BLANK    = 1000,
  parameter int AW       = $clog2(NDIG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [3:0]      wr_data,
  input  logic [NDIG-1:0] blank_mask,
  output logic [3:0]      number,
  output logic [NDIG-1:0] digit_sel,
  output logic            frame_tick
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [PW-1:0] LP_PMAX  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] LP_BLANK = PW'(BLANK);
  localparam logic [AW-1:0] LP_IMAX  = AW'(NDIG - 1);
  localparam logic [AW:0]   LP_NDIG  = (AW + 1)'(NDIG);

  logic [PW-1:0]         r_pre;
  logic [AW-1:0]         r_idx;
  logic [NDIG-1:0][3:0]  r_shadow;
  logic [NDIG-1:0][3:0]  r_active;

  logic                  w_pre_wrap;
  logic                  w_tick;
  logic                  w_wr_ok;
  logic                  w_dark;
  logic [PW-1:0]         w_pre_nxt;
  logic [AW-1:0]         w_idx_nxt;

  // state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pre    <= '0;
      r_idx    <= '0;
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      r_pre <= w_pre_nxt;
      r_idx <= w_idx_nxt;
      // commit reads the pre-edge shadow, so a same-edge write waits a frame
      if (w_tick)
        r_active <= r_shadow;
      if (w_wr_ok)
        r_shadow[wr_addr] <= wr_data;
    end
  end

  // next-state logic
  always_comb begin
    w_pre_wrap = (r_pre == LP_PMAX);
    w_tick     = w_pre_wrap && (r_idx == LP_IMAX);
    w_pre_nxt  = w_pre_wrap ? '0 : r_pre + PW'(1);
    w_idx_nxt  = r_idx;
    if (w_pre_wrap)
      w_idx_nxt = (r_idx == LP_IMAX) ? '0 : r_idx + AW'(1);
    w_wr_ok    = wr_en && ({1'b0, wr_addr} < LP_NDIG);
  end

  // output decode
  always_comb begin
    w_dark     = (r_pre < LP_BLANK) || blank_mask[r_idx];
    number     = r_active[r_idx];
    digit_sel  = '1;
    frame_tick = w_tick;
    if (!w_dark)
      digit_sel[r_idx] = 1'b0;
    // hold the outputs quiet for the whole time reset is asserted,
    // including the cycle before the first reset edge
    if (!rst) begin
      number     = '0;
      digit_sel  = '1;
      frame_tick = 1'b0;
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: scoreboard bench for display_scan.
// Two instances: NDIG=4/SCAN_DIV=8/BLANK=2 and NDIG=3/SCAN_DIV=4/BLANK=1.
module tb_display_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst = 1'b0;
  logic       a_we = 1'b0;
  logic [1:0] a_addr = '0;
  logic [3:0] a_data = '0;
  logic [3:0] a_mask = '0;
  logic [3:0] a_num;
  logic [3:0] a_sel;
  logic       a_tick;

  logic       b_rst = 1'b0;
  logic       b_we = 1'b0;
  logic [1:0] b_addr = '0;
  logic [3:0] b_data = '0;
  logic [2:0] b_mask = '0;
  logic [3:0] b_num;
  logic [2:0] b_sel;
  logic       b_tick;

  display_scan #(
    .NDIG(4), .SCAN_DIV(8), .BLANK(2), .AW(2)
  ) u_a (
    .clk(clk), .rst(a_rst),
    .wr_en(a_we), .wr_addr(a_addr), .wr_data(a_data),
    .blank_mask(a_mask),
    .number(a_num), .digit_sel(a_sel), .frame_tick(a_tick)
  );

  display_scan #(
    .NDIG(3), .SCAN_DIV(4), .BLANK(1), .AW(2)
  ) u_b (
    .clk(clk), .rst(b_rst),
    .wr_en(b_we), .wr_addr(b_addr), .wr_data(b_data),
    .blank_mask(b_mask),
    .number(b_num), .digit_sel(b_sel), .frame_tick(b_tick)
  );

  typedef struct {
    int         cyc;
    logic [3:0] num;
    logic [3:0] sel;
    logic       tk;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  logic [3:0] m_sh[4];
  logic [3:0] m_act[4];
  int         m_cyc = 0;

  task automatic a_cycle(input logic r, input logic we,
                         input logic [1:0] ad, input logic [3:0] d,
                         input logic [3:0] mk);
    exp_t e;
    int   pos;
    int   slot;
    #1;
    a_rst = r; a_we = we; a_addr = ad; a_data = d; a_mask = mk;
    e.cyc = r ? m_cyc : -1;
    if (!r) begin
      e.num = 4'h0; e.sel = 4'hF; e.tk = 1'b0;
    end else begin
      pos   = m_cyc % 8;
      slot  = (m_cyc / 8) % 4;
      e.num = m_act[slot];
      e.sel = (pos < 2 || mk[slot]) ? 4'hF : ~(4'b0001 << slot);
      e.tk  = ((m_cyc % 32) == 31);
    end
    qa.push_back(e);
    @(posedge clk);
    if (!r) begin
      for (int i = 0; i < 4; i++) begin
        m_sh[i]  = 4'h0;
        m_act[i] = 4'h0;
      end
      m_cyc = 0;
    end else begin
      if (e.tk)
        for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
      if (we) m_sh[ad] = d;
      m_cyc++;
    end
  endtask

  task automatic b_cycle(input logic r, input logic we,
                         input logic [1:0] ad, input logic [3:0] d,
                         input int c, input logic [3:0] xn,
                         input logic [2:0] xs, input logic xt);
    exp_t e;
    #1;
    b_rst = r; b_we = we; b_addr = ad; b_data = d; b_mask = '0;
    e.cyc = c; e.num = xn; e.sel = {1'b1, xs}; e.tk = xt;
    qb.push_back(e);
    @(posedge clk);
  endtask

  task automatic seq_a();
    logic       we;
    logic [1:0] ad;
    logic [3:0] d;
    for (int i = 0; i < 3; i++) a_cycle(1'b0, 1'b1, 2'd1, 4'hF, 4'h0);
    // frames 0..2: write 2<=7 at cycle 5, 0<=9 on the commit edge (31)
    for (int i = 0; i < 96; i++) begin
      we = (i == 5) || (i == 31);
      ad = (i == 5) ? 2'd2 : 2'd0;
      d  = (i == 5) ? 4'h7 : 4'h9;
      a_cycle(1'b1, we, ad, d, 4'h0);
    end
    // frame 3: digit 1 masked
    for (int i = 96; i < 128; i++) a_cycle(1'b1, 1'b0, 2'd0, 4'h0, 4'b0010);
    // frame 4: fill 1,2,3,4
    for (int i = 128; i < 160; i++) begin
      we = (i < 132);
      ad = 2'(i - 128);
      d  = 4'(i - 127);
      a_cycle(1'b1, we, ad, d, 4'h0);
    end
    // frame 5: reset at cycle 13 of the frame
    for (int i = 0; i < 13; i++) a_cycle(1'b1, 1'b0, 2'd0, 4'h0, 4'h0);
    for (int i = 0; i < 2; i++) a_cycle(1'b0, 1'b0, 2'd0, 4'h0, 4'h0);
    for (int i = 0; i < 40; i++) a_cycle(1'b1, 1'b0, 2'd0, 4'h0, 4'h0);
  endtask

  task automatic seq_b();
    logic       we;
    logic [1:0] ad;
    logic [3:0] d;
    logic [3:0] xn;
    logic [2:0] xs;
    int         slot;
    for (int i = 0; i < 2; i++)
      b_cycle(1'b0, 1'b0, 2'd0, 4'h0, -1, 4'h0, 3'b111, 1'b0);
    // cycle 0: 1<=5 accepted; cycle 1: addr 3 is out of range
    for (int c = 0; c < 24; c++) begin
      we   = (c < 2);
      ad   = (c == 0) ? 2'd1 : 2'd3;
      d    = (c == 0) ? 4'h5 : 4'hF;
      xn   = (c >= 16 && c < 20) ? 4'h5 : 4'h0;
      slot = (c / 4) % 3;
      xs   = ((c % 4) == 0) ? 3'b111 : ~(3'b001 << slot);
      b_cycle(1'b1, we, ad, d, c, xn, xs, (c == 11) || (c == 23));
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        n_vec++;
        if ({a_num, a_sel, a_tick} !== {e.num, e.sel, e.tk}) begin
          n_bad++;
          $display("FAIL dutA cyc=%0d: got num=%h sel=%b tick=%b, want num=%h sel=%b tick=%b",
                   e.cyc, a_num, a_sel, a_tick, e.num, e.sel, e.tk);
        end
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        n_vec++;
        if ({b_num, b_sel, b_tick} !== {e.num, e.sel[2:0], e.tk}) begin
          n_bad++;
          $display("FAIL dutB cyc=%0d: got num=%h sel=%b tick=%b, want num=%h sel=%b tick=%b",
                   e.cyc, b_num, b_sel, b_tick, e.num, e.sel[2:0], e.tk);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin : stim
    for (int i = 0; i < 4; i++) begin
      m_sh[i]  = 4'h0;
      m_act[i] = 4'h0;
    end
    @(posedge clk);
    fork
      seq_a();
      seq_b();
    join
    @(negedge clk);
    #1;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d/%0d entries left, want 0/0", qa.size(), qb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
